inv_sub_bytes_seq: RTL and testbench

- Sequential InvSubBytes unit for the AES-128 decryption datapath; the inverse direction of the `sbox` forward SubBytes table.
- Accepts a 128-bit state over a valid/ready handshake.
- Substitutes BPC bytes per cycle through the FIPS-197 inverse S-box, then presents the 128-bit result over a second valid/ready handshake.
- Sits between InvShiftRows and AddRoundKey in the iterative decryption round.

---
 rtl/inv_sub_bytes_seq.sv | 113 +++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes: substitutes BPC bytes of a 128-bit state per cycle,
// then holds the result on a valid/ready output until the consumer takes it.
module inv_sub_bytes_seq #(
  parameter int BPC = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  // state | meaning
  // IDLE  | waiting for a new state, in_ready high
  // RUN   | substituting BPC bytes per edge, cnt selects the byte group
  // DONE  | result held on out_state until out_ready

  localparam int R  = 16 / BPC;
  localparam int CW = (R > 1) ? $clog2(R) : 1;
  localparam int SW = 8 * BPC;
  localparam logic [7:0] INV_AFF_C = 8'h05;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] acc;
    logic [7:0] t;
    acc = 8'h00;
    t   = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) acc = acc ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Inverse affine, then GF(2^8) inverse as b^254 (zero maps to zero for free).
  function automatic logic [7:0] invsb(input logic [7:0] a);
    logic [7:0] b;
    logic [7:0] p;
    logic [7:0] r;
    for (int i = 0; i < 8; i++)
      b[i] = a[(i + 2) % 8] ^ a[(i + 5) % 8] ^ a[(i + 7) % 8] ^ INV_AFF_C[i];
    p = b;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  state_t         state, state_next;
  logic [CW-1:0]  cnt;
  logic [127:0]   work, work_next;
  logic [SW-1:0]  slice_in, slice_out;
  logic [6:0]     sh;
  logic           accept, last;

  assign accept = in_valid && in_ready;
  assign last   = (cnt == CW'(R - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = in_valid ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    out_state = work;
  end

  // Byte 0 sits in the top bits, so group cnt starts 128 - SW*(cnt+1) from the bottom.
  always_comb begin
    sh        = 7'(128 - SW * (int'(cnt) + 1));
    slice_in  = work[sh +: SW];
    slice_out = slice_in;
    for (int j = 0; j < BPC; j++)
      slice_out[SW-1-8*j -: 8] = invsb(slice_in[SW-1-8*j -: 8]);
    work_next = work;
    work_next[sh +: SW] = slice_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work <= '0;
      cnt  <= '0;
    end else if (accept) begin
      work <= in_state;
      cnt  <= '0;
    end else if (state == RUN) begin
      work <= work_next;
      cnt  <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: one instance per legal BPC, reference model built
// from brute-force GF inversion and the forward affine map, then table-inverted.
module tb_inv_sub_bytes_seq;

  localparam int M = 2;  // index of the BPC = 4 instance
  localparam logic [127:0] VEC_IN  = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
  localparam logic [127:0] VEC_OUT = 128'hbdb52189f261b63d0b107c9e8b6e776e;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_state;
  logic         ir [5];
  logic         ov [5];
  logic         bz [5];
  logic [127:0] os [5];

  int checks = 0;
  int errors = 0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 5; g++) begin : gen_dut
      inv_sub_bytes_seq #(.BPC(1 << g)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(ir[g]), .in_state(in_state),
        .out_valid(ov[g]), .out_ready(out_ready), .out_state(os[g]),
        .busy(bz[g])
      );
    end
  endgenerate

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] poly_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (poly_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      fwd_tab[a] = s;
      inv_tab[s] = 8'(a);
    end
  endtask

  function automatic logic [127:0] ref_state(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[127-8*i -: 8] = inv_tab[s[127-8*i -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Accept s on the BPC=4 instance, wait for out_valid, take the result.
  task automatic run_one(input logic [127:0] s, output logic [127:0] res, output int lat);
    in_state  = s;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!ov[M] && lat < 40) begin
      step();
      lat++;
    end
    res = os[M];
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_state = '0;
    step();
    step();
    checks++;
    if (ov[M] !== 1'b0 || os[M] !== '0 || bz[M] !== 1'b0 || ir[M] !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b state=%h busy=%b ready=%b, want 0 0 0 0",
               ov[M], os[M], bz[M], ir[M]);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ir[M] !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", ir[M]);
    end
  endtask

  task automatic test_vector();
    int lat;
    in_state = VEC_IN;
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!ov[M] && lat < 40) begin
      checks++;
      if (ir[M] !== 1'b0 || bz[M] !== 1'b1) begin
        errors++;
        $display("FAIL vector_run_flags: ready=%b busy=%b want 0 1", ir[M], bz[M]);
      end
      step();
      lat++;
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL vector_latency: got %0d want 4", lat);
    end
    checks++;
    if (os[M] !== VEC_OUT || os[M] !== ref_state(VEC_IN)) begin
      errors++;
      $display("FAIL vector_result: got %h want %h", os[M], VEC_OUT);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (ov[M] !== 1'b0 || ir[M] !== 1'b1 || bz[M] !== 1'b0) begin
      errors++;
      $display("FAIL vector_return_idle: valid=%b ready=%b busy=%b want 0 1 0",
               ov[M], ir[M], bz[M]);
    end
  endtask

  task automatic test_exhaustive();
    logic [127:0] res;
    int lat;
    for (int x = 0; x < 256; x++) begin
      run_one({16{fwd_tab[x]}}, res, lat);
      checks++;
      if (res !== {16{8'(x)}}) begin
        errors++;
        $display("FAIL exhaustive_byte x=%02h: got %h want %h", x, res, {16{8'(x)}});
      end
    end
  endtask

  task automatic test_random();
    logic [127:0] s, res;
    int lat;
    for (int n = 0; n < 20; n++) begin
      s = rand128();
      run_one(s, res, lat);
      checks++;
      if (res !== ref_state(s) || lat != 4) begin
        errors++;
        $display("FAIL random_state in=%h: got %h lat %0d want %h lat 4",
                 s, res, lat, ref_state(s));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] s, held;
    int lat;
    s = rand128();
    in_state = s;
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!ov[M] && lat < 40) begin
      step();
      lat++;
    end
    held = os[M];
    checks++;
    if (held !== ref_state(s)) begin
      errors++;
      $display("FAIL backpressure_result: got %h want %h", held, ref_state(s));
    end
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      in_state = rand128();
      step();
      checks++;
      if (ov[M] !== 1'b1 || os[M] !== held || ir[M] !== 1'b0 || bz[M] !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_hold c=%0d: valid=%b state=%h ready=%b busy=%b want 1 %h 0 1",
                 c, ov[M], os[M], ir[M], bz[M], held);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (ov[M] !== 1'b0 || ir[M] !== 1'b1 || bz[M] !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: valid=%b ready=%b busy=%b want 0 1 0",
               ov[M], ir[M], bz[M]);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] s1, s2;
    int lat;
    s1 = rand128();
    s2 = rand128();
    in_state = s1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_state = s2;
    lat = 0;
    while (!ov[M] && lat < 40) begin
      step();
      lat++;
    end
    checks++;
    if (os[M] !== ref_state(s1) || ir[M] !== 1'b1 || lat != 4) begin
      errors++;
      $display("FAIL b2b_first: got %h ready=%b lat %0d want %h ready=1 lat 4",
               os[M], ir[M], lat, ref_state(s1));
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (ov[M] !== 1'b0 || bz[M] !== 1'b1 || ir[M] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_handoff: valid=%b busy=%b ready=%b want 0 1 0", ov[M], bz[M], ir[M]);
    end
    lat = 0;
    while (!ov[M] && lat < 40) begin
      step();
      lat++;
    end
    checks++;
    if (os[M] !== ref_state(s2) || lat != 4) begin
      errors++;
      $display("FAIL b2b_second: got %h lat %0d want %h lat 4", os[M], lat, ref_state(s2));
    end
    step();
    out_ready = 1'b0;
    checks++;
    if (ov[M] !== 1'b0 || bz[M] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: valid=%b busy=%b want 0 0", ov[M], bz[M]);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [127:0] s, res;
    int lat;
    in_state = rand128();
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if (ov[M] !== 1'b0 || os[M] !== '0 || bz[M] !== 1'b0 || ir[M] !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: valid=%b state=%h busy=%b ready=%b want 0 0 0 0",
               ov[M], os[M], bz[M], ir[M]);
    end
    rst = 1'b0;
    #1;
    s = rand128();
    run_one(s, res, lat);
    checks++;
    if (res !== ref_state(s) || lat != 4) begin
      errors++;
      $display("FAIL midrun_recover: got %h lat %0d want %h lat 4", res, lat, ref_state(s));
    end
  endtask

  task automatic test_sweep();
    int lat [5];
    logic [127:0] res [5];
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    step();
    rst = 1'b0;
    in_state = VEC_IN;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      lat[k] = -1;
      res[k] = '0;
    end
    for (int n = 1; n <= 20; n++) begin
      for (int k = 0; k < 5; k++)
        if (lat[k] < 0 && ov[k]) begin
          lat[k] = n - 1;
          res[k] = os[k];
        end
      step();
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (lat[k] != (16 >> k) || res[k] !== VEC_OUT) begin
        errors++;
        $display("FAIL sweep_bpc%0d: got %h lat %0d want %h lat %0d",
                 1 << k, res[k], lat[k], VEC_OUT, 16 >> k);
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    build_tables();
    test_reset();
    test_vector();
    test_exhaustive();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
